// File: rtl/seq_fp_subtractor.sv
// Multi-cycle IEEE-754 single-precision subtractor (result = a - b).
// One-bit-per-cycle alignment and normalisation behind a start/done handshake.
module seq_fp_subtractor (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_COMPUTE,
    S_NORM,
    S_DONE
  } state_t;

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;
  logic        sign_q;
  logic        sub_q;
  logic [7:0]  exp_q;
  logic [24:0] mx_q;
  logic [24:0] my_q;
  logic [4:0]  cnt_q;

  logic [7:0]  ea, eb, ex_d, ey_d, diff;
  logic [22:0] fa, fb;
  logic        sa, sb, a_ge, sign_d, sub_d;
  logic [24:0] mx_d, my_d;
  logic [4:0]  s_d;

  // Operand flush, magnitude swap and shift distance, evaluated on the raw inputs
  // so that everything is captured in the single IDLE acceptance cycle.
  always_comb begin
    ea   = a[30:23];
    eb   = b[30:23];
    fa   = (ea == '0) ? '0 : a[22:0];
    fb   = (eb == '0) ? '0 : b[22:0];
    sa   = a[31];
    sb   = ~b[31];
    a_ge = ({ea, fa} >= {eb, fb});
    if (a_ge) begin
      ex_d   = ea;
      ey_d   = eb;
      mx_d   = {1'b0, ea != '0, fa};
      my_d   = {1'b0, eb != '0, fb};
      sign_d = sa;
    end else begin
      ex_d   = eb;
      ey_d   = ea;
      mx_d   = {1'b0, eb != '0, fb};
      my_d   = {1'b0, ea != '0, fa};
      sign_d = sb;
    end
    sub_d = sa ^ sb;
    diff  = ex_d - ey_d;
    s_d   = (diff > 8'd24) ? 5'd24 : diff[4:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      exp_q    <= '0;
      mx_q     <= '0;
      my_q     <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            exp_q   <= ex_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            cnt_q   <= s_d;
            busy_q  <= 1'b1;
            state_q <= (s_d != '0) ? S_ALIGN : S_COMPUTE;
          end
        end
        S_ALIGN: begin
          my_q  <= my_q >> 1;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_q <= S_COMPUTE;
        end
        S_COMPUTE: begin
          mx_q    <= sub_q ? (mx_q - my_q) : (mx_q + my_q);
          state_q <= S_NORM;
        end
        S_NORM: begin
          // Overflow and underflow finish on the shifting cycle itself.
          if (mx_q == '0) begin
            result_q <= '0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (mx_q[24]) begin
            mx_q  <= mx_q >> 1;
            exp_q <= exp_q + 8'd1;
            if (exp_q == 8'd254) begin
              result_q <= {sign_q, 8'hFF, 23'd0};
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end else if (!mx_q[23]) begin
            mx_q  <= mx_q << 1;
            exp_q <= exp_q - 8'd1;
            if (exp_q == 8'd1) begin
              result_q <= '0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end else begin
            result_q <= {sign_q, exp_q, mx_q[22:0]};
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_fp_subtractor.sv
// Scoreboard bench for seq_fp_subtractor: directed cases with hand-derived answers,
// then random traffic checked against a closed-form reference of the subtraction rules.
module tb_seq_fp_subtractor;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  seq_fp_subtractor dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } dir_t;

  exp_t        q[$];
  int          cyc = 0;
  int          free_edge = 0;
  int          busy_end = -1;
  bit          chk_on = 1'b0;
  bit          rst_edge = 1'b0;
  int          tests = 0;
  int          fails = 0;
  logic        use_dir = 1'b0;
  logic [31:0] dir_res = '0;
  int          dir_lat = 0;
  logic [31:0] last_res = '0;

  // Reference: the value and the edge count of the done pulse, from the arithmetic rules.
  // A NORM shift that overflows to Inf or underflows to zero completes on that same cycle.
  function automatic void ref_sub(input logic [31:0] ia, input logic [31:0] ib,
                                  output logic [31:0] r, output int lat);
    int ea, eb, ex, s, k, p;
    longint mag_a, mag_b;
    logic [63:0] ma, mb, mx, my, m, mv;
    bit sa, sb, sx;
    ea    = int'(ia[30:23]);
    eb    = int'(ib[30:23]);
    ma    = (ea == 0) ? 64'd0 : (64'd1 << 23) + 64'(ia[22:0]);
    mb    = (eb == 0) ? 64'd0 : (64'd1 << 23) + 64'(ib[22:0]);
    mag_a = (ea == 0) ? 0 : longint'(ea) * 8388608 + longint'(ia[22:0]);
    mag_b = (eb == 0) ? 0 : longint'(eb) * 8388608 + longint'(ib[22:0]);
    sa    = ia[31];
    sb    = !ib[31];
    if (mag_a >= mag_b) begin
      ex = ea; s = ea - eb; mx = ma; my = mb; sx = sa;
    end else begin
      ex = eb; s = eb - ea; mx = mb; my = ma; sx = sb;
    end
    if (s > 24) s = 24;
    my  = my >> s;
    m   = (sa == sb) ? mx + my : mx - my;
    lat = s + 2;
    r   = '0;
    if (m == 0) begin
      r = '0;
    end else if (m >= (64'd1 << 24)) begin
      if (ex == 254) begin
        r = {sx, 8'hFF, 23'd0};
      end else begin
        mv  = m >> 1;
        r   = {sx, 8'(ex + 1), mv[22:0]};
        lat = lat + 1;
      end
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (m[i]) p = i;
      k = 23 - p;
      if (ex <= k) begin
        r   = '0;
        lat = lat + ex - 1;
      end else begin
        mv  = m << k;
        r   = {sx, 8'(ex - k), mv[22:0]};
        lat = lat + k;
      end
    end
  endfunction

  function automatic logic [31:0] rand_a();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[30:23] = 8'd0;
      1: r[30:23] = 8'($urandom_range(1, 3));
      default: ;
    endcase
    if (r[30:23] == 8'hFF) r[30:23] = 8'hFE;
    return r;
  endfunction

  function automatic logic [31:0] rand_b(input logic [31:0] ra);
    logic [31:0] r;
    int e;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1: r[30:0] = ra[30:0];
      default: begin
        e = int'(ra[30:23]) + int'($urandom_range(0, 4)) - 2;
        if (e < 0) e = 0;
        if (e > 254) e = 254;
        r[30:23] = 8'(e);
        if ($urandom_range(0, 1) == 1) r[22:0] = ra[22:0] ^ (23'd1 << $urandom_range(0, 22));
      end
    endcase
    if (r[30:23] == 8'hFF) r[30:23] = 8'hFE;
    return r;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b, expected %b", nm, cyc, act, req);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %08h, expected %08h", nm, cyc, act, req);
    end
  endtask

  // Handshake model: decides acceptances and schedules expected done pulses.
  initial forever begin
    logic [31:0] r;
    int          lat;
    exp_t        e;
    @(posedge clk);
    cyc++;
    rst_edge = rst;
    if (rst) begin
      q.delete();
      free_edge = cyc + 1;
      busy_end  = cyc - 1;
      chk_on    = 1'b1;
    end else if (start && cyc >= free_edge) begin
      if (use_dir) begin
        r = dir_res; lat = dir_lat;
      end else begin
        ref_sub(a, b, r, lat);
      end
      e.res = r;
      e.cyc = cyc + lat;
      q.push_back(e);
      free_edge = cyc + lat + 2;
      busy_end  = cyc + lat;
    end
  end

  // Monitor, sampling half a cycle after each active edge.
  initial forever begin
    bit exp_done;
    @(negedge clk);
    if (chk_on) begin
      if (rst_edge) last_res = '0;
      exp_done = (q.size() > 0) && (q[0].cyc == cyc);
      if (exp_done) begin
        last_res = q[0].res;
        void'(q.pop_front());
      end
      chk1("done", done, exp_done);
      chk1("busy", busy, cyc <= busy_end);
      chk32("result", result, last_res);
    end
  end

  initial begin
    dir_t dirs[7];
    dirs[0] = '{32'h40400000, 32'h3F800000, 32'h40000000, 3};
    dirs[1] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 2};
    dirs[2] = '{32'h00000000, 32'h00000000, 32'h00000000, 2};
    dirs[3] = '{32'h3F800000, 32'hBF800000, 32'h40000000, 3};
    dirs[4] = '{32'h3F800000, 32'h3FC00000, 32'hBF000000, 3};
    dirs[5] = '{32'h4B800000, 32'h3F800000, 32'h4B800000, 26};
    dirs[6] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 2};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (dirs[i]) begin
      @(negedge clk);
      start = 1'b1; a = dirs[i].a; b = dirs[i].b;
      use_dir = 1'b1; dir_res = dirs[i].res; dir_lat = dirs[i].lat;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      repeat (dirs[i].lat + 3) @(negedge clk);
    end

    // Start held high: a fresh acceptance only on each return to IDLE.
    @(negedge clk);
    start = 1'b1; a = 32'h40400000; b = 32'h3F800000;
    dir_res = 32'h40000000; dir_lat = 3;
    repeat (12) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Reset in the middle of a long alignment.
    start = 1'b1; a = 32'h4B800000; b = 32'h3F800000;
    dir_res = 32'h4B800000; dir_lat = 26;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    use_dir = 1'b0;
    repeat (4000) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 999) == 0);
      start = ($urandom_range(0, 3) == 0);
      a     = rand_a();
      b     = rand_b(a);
    end
    start = 1'b0; rst = 1'b0;
    repeat (60) @(negedge clk);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_done: %0d responses never arrived, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
